// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter sharing the single-port data_memory between
// the CPU (port 0) and a secondary requester (port 1, e.g. loader or debug).
// One transaction is in flight at a time; each takes 3 cycles from the
// request sample edge to the ack pulse (IDLE sample -> ISSUE -> WAIT -> ack).
//
// Configuration macro:
//   DM_ARB_FIXED_PRIO_EN  defined   : port 0 always wins contention
//                         undefined : round-robin using last_grant
//
// Handshake: a requester raises pN_req with pN_wr/pN_addr/pN_wdata and holds
// it until pN_ack. pN_ack is a one-cycle pulse; a request still high in the
// ack cycle is ignored, a request high in the following cycle is new. The
// command is latched at grant, so later changes on the inputs have no effect.
//
// Ports:
//   clk, reset          clock (rising edge), async active-low reset
//   pN_req/wr/addr/wdata request from port N (0 = CPU, 1 = secondary)
//   pN_ack, pN_rdata    completion pulse and read data (held until next read)
//   mem_WrRd            {Wr,Rd} strobe pair to data_memory, active in ISSUE
//   mem_addr/mem_inData address and write data to data_memory
//   mem_outData         read data from data_memory, valid the cycle after Rd
//   busy                high in ISSUE and WAIT
//   state_dbg           FSM state (0 = IDLE, 1 = ISSUE, 2 = WAIT)

module dm_arbiter #(
    parameter int ADDR_LENGTH = 11,
    parameter int DATA_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   p0_req,
    input  logic                   p0_wr,
    input  logic [ADDR_LENGTH-1:0] p0_addr,
    input  logic [DATA_LENGTH-1:0] p0_wdata,
    output logic                   p0_ack,
    output logic [DATA_LENGTH-1:0] p0_rdata,
    input  logic                   p1_req,
    input  logic                   p1_wr,
    input  logic [ADDR_LENGTH-1:0] p1_addr,
    input  logic [DATA_LENGTH-1:0] p1_wdata,
    output logic                   p1_ack,
    output logic [DATA_LENGTH-1:0] p1_rdata,
    output logic [1:0]             mem_WrRd,
    output logic [ADDR_LENGTH-1:0] mem_addr,
    output logic [DATA_LENGTH-1:0] mem_inData,
    input  logic [DATA_LENGTH-1:0] mem_outData,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic                   grant_valid;
    logic                   grant_id;
    logic                   req0_eff;
    logic                   req1_eff;

    logic                   lat_wr;
    logic                   lat_id;
    logic [ADDR_LENGTH-1:0] lat_addr;
    logic [DATA_LENGTH-1:0] lat_wdata;

`ifndef DM_ARB_FIXED_PRIO_EN
    logic                   last_grant;
`endif

    // A port whose ack is high this cycle has just completed; its req is
    // still up only because the requester sees the ack in this same cycle.
    assign req0_eff = p0_req & ~p0_ack;
    assign req1_eff = p1_req & ~p1_ack;

    // Next-state and grant decision
    always_comb begin
        next_state  = state;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (state)
            IDLE: begin
                if (req0_eff && req1_eff) begin
                    grant_valid = 1'b1;
`ifdef DM_ARB_FIXED_PRIO_EN
                    grant_id    = 1'b0;
`else
                    grant_id    = ~last_grant;
`endif
                end else if (req0_eff) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end else if (req1_eff) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
                if (grant_valid) begin
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = WAIT;
            WAIT:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latched command, grant bookkeeping, acks and read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_wr     <= 1'b0;
            lat_id     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
`ifndef DM_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            if (state == IDLE && grant_valid) begin
                lat_id     <= grant_id;
                lat_wr     <= grant_id ? p1_wr    : p0_wr;
                lat_addr   <= grant_id ? p1_addr  : p0_addr;
                lat_wdata  <= grant_id ? p1_wdata : p0_wdata;
`ifndef DM_ARB_FIXED_PRIO_EN
                last_grant <= grant_id;
`endif
            end
            if (state == WAIT) begin
                if (lat_id == 1'b0) begin
                    p0_ack <= 1'b1;
                    if (!lat_wr) begin
                        p0_rdata <= mem_outData;
                    end
                end else begin
                    p1_ack <= 1'b1;
                    if (!lat_wr) begin
                        p1_rdata <= mem_outData;
                    end
                end
            end
        end
    end

    // Strobes only in ISSUE; {Wr,Rd} are mutually exclusive by construction.
    // Address and data come straight from the latch so they hold through WAIT.
    assign mem_WrRd   = (state == ISSUE) ? {lat_wr, ~lat_wr} : 2'b00;
    assign mem_addr   = lat_addr;
    assign mem_inData = lat_wdata;
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-port arbiter that shares the single-port data_memory between the CPU (port 0) and a secondary requester (port 1), e.g. a loader or debug master. It sits between cpu/loader and data_memory, drives data_memory's {Wr,Rd} strobe pair, address and write data, and returns read data and a completion pulse to the granted requester. One transaction is in flight at a time. Each transaction takes a fixed 3 cycles from request sample to ack.

Parameters:
ADDR_LENGTH, 11, data-memory address width
DATA_LENGTH, 16, data word width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
p0_req  input  1  port 0 (CPU) access request; held until p0_ack
p0_wr  input  1  port 0: 1 = write, 0 = read
p0_addr  input  ADDR_LENGTH  port 0 address
p0_wdata  input  DATA_LENGTH  port 0 write data
p0_ack  output  1  port 0 one-cycle completion pulse
p0_rdata  output  DATA_LENGTH  port 0 read data, valid while p0_ack=1, held until next port-0 read completes
p1_req, p1_wr, p1_addr, p1_wdata, p1_ack, p1_rdata  same directions/widths/meaning for port 1
mem_WrRd  output  2  to data_memory WrRd, {Wr,Rd}
mem_addr  output  ADDR_LENGTH  to data_memory addr
mem_inData  output  DATA_LENGTH  to data_memory inData
mem_outData  input  DATA_LENGTH  from data_memory outData; valid the cycle after Rd is driven
busy  output  1  high in ISSUE and WAIT

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, latched request regs 0, last_grant=1 (so port 0 wins first contention).
- FSM states IDLE, ISSUE, WAIT.
- IDLE: sample requests, excluding any port whose ack is high this cycle. None -> stay. One -> grant it. Both -> round-robin: grant port != last_grant. On grant: latch wr/addr/wdata and grant id, update last_grant, go ISSUE.
- ISSUE (1 cycle): mem_addr=latched addr; mem_inData=latched wdata; mem_WrRd=2'b10 for write, 2'b01 for read. Go WAIT.
- WAIT (1 cycle): mem_WrRd=2'b00; mem_addr/mem_inData hold. At edge ending WAIT: for reads, load granted pN_rdata from mem_outData; for both reads and writes, set granted pN_ack=1. Go IDLE.
- pN_ack is registered, high exactly one cycle (first IDLE cycle after WAIT), then cleared.
- Latency: req sampled at edge E -> ISSUE in cycle E+1 -> WAIT in cycle E+2 -> ack in cycle E+3. Back-to-back throughput is one transaction per 3 cycles.
- Requester drops req in its ack cycle. Req still high in that cycle is ignored. Req high the following cycle is a new request.
- mem_WrRd is never 2'b11. Both strobes are 0 outside ISSUE.
- Request inputs changing after grant have no effect (latched copy used).
- Reset asserted mid-transaction aborts it: no ack, strobes drop asynchronously, rdata cleared.
- Ungranted port's rdata is unchanged. A write never changes rdata.

Optional Feature:
DM_ARB_FIXED_PRIO_EN
- Defined: fixed priority, port 0 (CPU) always wins contention; last_grant is not used.
- Undefined: round-robin as above.

Test Plan:
- Reset, then p0 read addr 0x005 with mem preloaded 0x1234 -> mem_WrRd=01 one cycle at cycle 1, p0_ack pulse at cycle 3, p0_rdata=0x1234; p1_ack stays 0.
- p1 write 0x7FF<-0xBEEF, then p0 read 0x7FF -> p1_ack after 3 cycles with mem_WrRd=10 once; p0_rdata=0xBEEF.
- p0_req and p1_req held high continuously, addrs 0x010/0x020, round-robin build -> grants p0,p1,p0,p1; acks every 3 cycles alternating; never 11 on mem_WrRd.
- Same contention with DM_ARB_FIXED_PRIO_EN, p0 dropping req for one cycle after each ack -> p0 granted whenever requesting; p1 granted only in cycles where p0_req=0.
- Assert reset during WAIT of a p0 read -> no p0_ack, mem_WrRd=00, p0_rdata=0, state IDLE; next p1 read completes normally with ack 3 cycles after req.
- p0 keeps req high in its ack cycle -> no duplicate transaction from that cycle. req held into the next cycle -> new transaction starts.
